// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control bundle, opcodes and the bubble constant.
package mips_pipe_pkg;

  localparam int ALUOP_W = 4;

  typedef struct packed {
    logic               regDst;
    logic               branchEq;
    logic               branchNe;
    logic               memRead;
    logic               memToReg;
    logic               memWrite;
    logic               aluSrc;
    logic               regWrite;
    logic               jump;
    logic               jal;
    logic               jr;
    logic [ALUOP_W-1:0] aluOp;
  } ctrlBundle_t;

  localparam ctrlBundle_t CTRL_BUBBLE = '0;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the instruction in ID.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRt,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idJump,
  input  logic                  idJal,
  input  logic                  idRegDst,
  input  logic                  idMemWrite,
  input  logic                  idBranchEq,
  input  logic                  idBranchNe,
  input  logic                  flush,
  input  logic                  freeze,
  output logic                  loadUse,
  output logic                  stallReq
);

  logic usesRs, usesRt;

  assign usesRs = !(idJump | idJal);
  // addi/lw/lui write rt rather than read it, so only these forms source rt
  assign usesRt = idRegDst | idMemWrite | idBranchEq | idBranchNe;

  assign loadUse = exValid & exMemRead & (exRt != '0) &
                   (((exRt == idRs) & usesRs) | ((exRt == idRt) & usesRt));

  assign stallReq = idValid & loadUse & !flush & !freeze;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble, flush and freeze.
// Optional bubble counter enabled by ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_regdst,
  input  logic                  id_branch_eq,
  input  logic                  id_branch_ne,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_jump,
  input  logic                  id_jal,
  input  logic                  id_jr,
  input  logic [ALUOP_W-1:0]    id_alu_op,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [4:0]            id_shamt,
  output logic                  stall_req,
  output logic                  ex_valid,
  output logic                  ex_regdst,
  output logic                  ex_branch_eq,
  output logic                  ex_branch_ne,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_write,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_jump,
  output logic                  ex_jal,
  output logic                  ex_jr,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [4:0]            ex_shamt,
  output logic [CNT_W-1:0]      bubble_count
);
  import mips_pipe_pkg::*;

  ctrlBundle_t idCtrl, exCtrl;
  logic        loadUse, bubble;

  assign idCtrl = '{regDst: id_regdst, branchEq: id_branch_eq, branchNe: id_branch_ne,
                    memRead: id_mem_read, memToReg: id_mem_to_reg, memWrite: id_mem_write,
                    aluSrc: id_alu_src, regWrite: id_reg_write, jump: id_jump, jal: id_jal,
                    jr: id_jr, aluOp: id_alu_op};

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) uDetect (
    .exValid(ex_valid), .exMemRead(exCtrl.memRead), .exRt(ex_rt),
    .idValid(id_valid), .idRs(id_rs), .idRt(id_rt),
    .idJump(id_jump), .idJal(id_jal), .idRegDst(id_regdst), .idMemWrite(id_mem_write),
    .idBranchEq(id_branch_eq), .idBranchNe(id_branch_ne),
    .flush(flush), .freeze(freeze), .loadUse(loadUse), .stallReq(stall_req)
  );

  assign bubble = flush | (loadUse & id_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      exCtrl      <= CTRL_BUBBLE;
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_shamt    <= '0;
    end else if (!freeze) begin
      // data fields always follow ID; only validity and control get squashed
      ex_pc_plus4 <= id_pc_plus4;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_shamt    <= id_shamt;
      if (bubble) begin
        ex_valid <= 1'b0;
        exCtrl   <= CTRL_BUBBLE;
      end else begin
        ex_valid <= id_valid;
        exCtrl   <= id_valid ? idCtrl : CTRL_BUBBLE;
      end
    end
  end

  assign ex_regdst     = exCtrl.regDst;
  assign ex_branch_eq  = exCtrl.branchEq;
  assign ex_branch_ne  = exCtrl.branchNe;
  assign ex_mem_read   = exCtrl.memRead;
  assign ex_mem_to_reg = exCtrl.memToReg;
  assign ex_mem_write  = exCtrl.memWrite;
  assign ex_alu_src    = exCtrl.aluSrc;
  assign ex_reg_write  = exCtrl.regWrite;
  assign ex_jump       = exCtrl.jump;
  assign ex_jal        = exCtrl.jal;
  assign ex_jr         = exCtrl.jr;
  assign ex_alu_op     = exCtrl.aluOp;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubbleCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubbleCnt <= '0;
    else if (!freeze && bubble && !(&bubbleCnt))
      bubbleCnt <= bubbleCnt + 1'b1;
  end

  assign bubble_count = bubbleCnt;
`else
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for id_ex_stage_reg plus reset/saturation sequences.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset, freeze, flush, id_valid;
  logic [10:0] idC;
  logic [3:0]  id_alu_op;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic        stall_req, ex_valid;
  logic        ex_regdst, ex_branch_eq, ex_branch_ne, ex_mem_read, ex_mem_to_reg, ex_mem_write;
  logic        ex_alu_src, ex_reg_write, ex_jump, ex_jal, ex_jr;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [15:0] bubble_count;
  logic [10:0] exC;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // bit order: regdst beq bne memread memtoreg memwrite alusrc regwrite jump jal jr
  assign exC = {ex_regdst, ex_branch_eq, ex_branch_ne, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                ex_alu_src, ex_reg_write, ex_jump, ex_jal, ex_jr};

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_regdst(idC[10]), .id_branch_eq(idC[9]), .id_branch_ne(idC[8]), .id_mem_read(idC[7]),
    .id_mem_to_reg(idC[6]), .id_mem_write(idC[5]), .id_alu_src(idC[4]), .id_reg_write(idC[3]),
    .id_jump(idC[2]), .id_jal(idC[1]), .id_jr(idC[0]), .id_alu_op(id_alu_op),
    .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .stall_req(stall_req), .ex_valid(ex_valid),
    .ex_regdst(ex_regdst), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_jal(ex_jal),
    .ex_jr(ex_jr), .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .bubble_count(bubble_count)
  );

  localparam logic [10:0] LWC  = 11'h0D8;
  localparam logic [10:0] ADDC = 11'h408;
  localparam logic [10:0] ADIC = 11'h018;
  localparam logic [10:0] JC   = 11'h004;
  localparam logic [10:0] SWC  = 11'h030;

  typedef struct {
    logic        fl, fz, v;
    logic [10:0] c;
    logic [3:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] pc;
    logic        eStall, eValid;
    logic [10:0] eC;
    logic [3:0]  eOp;
    logic [4:0]  eRt;
    logic [31:0] ePc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] P(int i);
    return 32'h1000 + 32'(i * 4);
  endfunction

  task automatic add(input logic fl, fz, v, input logic [10:0] c, input logic [3:0] op,
                     input logic [4:0] rs, rt, input logic [31:0] pc,
                     input logic eS, eV, input logic [10:0] eC, input logic [3:0] eOp,
                     input logic [4:0] eRt, input logic [31:0] ePc);
    vec_t r;
    r.fl = fl; r.fz = fz; r.v = v; r.c = c; r.op = op; r.rs = rs; r.rt = rt; r.pc = pc;
    r.eStall = eS; r.eValid = eV; r.eC = eC; r.eOp = eOp; r.eRt = eRt; r.ePc = ePc;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    flush = r.fl; freeze = r.fz; id_valid = r.v; idC = r.c; id_alu_op = r.op;
    id_rs = r.rs; id_rt = r.rt; id_rd = r.rt + 5'd1; id_shamt = r.rs;
    id_pc_plus4 = r.pc; id_rs_data = r.pc + 1; id_rt_data = r.pc + 2; id_imm = r.pc + 3;
  endtask

  initial begin
    vec_t z;
    // lw / dependent add / re-present
    add(0,0,1,LWC ,0, 1, 8,P(0),  0,1,LWC ,0, 8,P(0));
    add(0,0,1,ADDC,2, 8,10,P(1),  1,0,0   ,0,10,P(1));
    add(0,0,1,ADDC,2, 8,10,P(2),  0,1,ADDC,2,10,P(2));
    // register 0 never hazards
    add(0,0,1,LWC ,0, 2, 0,P(3),  0,1,LWC ,0, 0,P(3));
    add(0,0,1,ADDC,2, 0, 3,P(4),  0,1,ADDC,2, 3,P(4));
    // jump does not use rs
    add(0,0,1,LWC ,0, 1, 8,P(5),  0,1,LWC ,0, 8,P(5));
    add(0,0,1,JC  ,0, 8, 0,P(6),  0,1,JC  ,0, 0,P(6));
    // load then two independent, then the consumer: no stall
    add(0,0,1,LWC ,0, 1, 8,P(7),  0,1,LWC ,0, 8,P(7));
    add(0,0,1,ADIC,1, 2, 8,P(8),  0,1,ADIC,1, 8,P(8));
    add(0,0,1,ADDC,2, 3, 4,P(9),  0,1,ADDC,2, 4,P(9));
    add(0,0,1,ADDC,2, 8, 8,P(10), 0,1,ADDC,2, 8,P(10));
    // flush valid addi
    add(1,0,1,ADIC,1, 2, 5,P(11), 0,0,0   ,0, 5,P(11));
    // flush with load-use: single bubble, no stall
    add(0,0,1,LWC ,0, 1, 8,P(12), 0,1,LWC ,0, 8,P(12));
    add(1,0,1,ADDC,2, 8,10,P(13), 0,0,0   ,0,10,P(13));
    // invalid ID forces control to 0
    add(0,0,0,ADDC,0, 3, 4,P(14), 0,0,0   ,0, 4,P(14));
    add(0,0,1,LWC ,0, 1, 8,P(15), 0,1,LWC ,0, 8,P(15));
    add(0,0,0,ADDC,0, 8,10,P(16), 0,0,0   ,0,10,P(16));
    // freeze holds, even with flush
    add(0,0,1,ADDC,2, 3, 4,P(17), 0,1,ADDC,2, 4,P(17));
    add(0,1,1,LWC ,0, 1, 8,P(18), 0,1,ADDC,2, 4,P(17));
    add(1,1,1,ADIC,1, 5, 6,P(19), 0,1,ADDC,2, 4,P(17));
    add(0,1,0,0   ,0, 7, 7,P(20), 0,1,ADDC,2, 4,P(17));
    // freeze suppresses stall; the hazard resolves after release
    add(0,0,1,LWC ,0, 1, 8,P(21), 0,1,LWC ,0, 8,P(21));
    add(0,1,1,ADDC,2, 8,10,P(22), 0,1,LWC ,0, 8,P(21));
    add(0,0,1,ADDC,2, 8,10,P(23), 1,0,0   ,0,10,P(23));
    add(0,0,1,ADDC,2, 8,10,P(24), 0,1,ADDC,2,10,P(24));
    add(1,0,0,0   ,0, 1, 2,P(25), 0,0,0   ,0, 2,P(25));
    // rt-side hazard through store data
    add(0,0,1,LWC ,0, 1, 8,P(26), 0,1,LWC ,0, 8,P(26));
    add(0,0,1,SWC ,0, 2, 8,P(27), 1,0,0   ,0, 8,P(27));
    add(0,0,1,SWC ,0, 2, 8,P(28), 0,1,SWC ,0, 8,P(28));

    z = '{default: '0};
    drive(z);
    reset = 1'b1;
    #12;
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_ctrl", 32'(exC), 0);
    chk("reset_pc", ex_pc_plus4, 0);
    chk("reset_cnt", 32'(bubble_count), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("stall[%0d]", i), 32'(stall_req), 32'(tbl[i].eStall));
      @(posedge clk); #1;
      chk($sformatf("valid[%0d]", i), 32'(ex_valid), 32'(tbl[i].eValid));
      chk($sformatf("ctrl[%0d]", i), 32'(exC), 32'(tbl[i].eC));
      chk($sformatf("aluop[%0d]", i), 32'(ex_alu_op), 32'(tbl[i].eOp));
      chk($sformatf("rt[%0d]", i), 32'(ex_rt), 32'(tbl[i].eRt));
      chk($sformatf("pc[%0d]", i), ex_pc_plus4, tbl[i].ePc);
      chk($sformatf("rsdata[%0d]", i), ex_rs_data, tbl[i].ePc + 1);
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bubble_cnt", 32'(bubble_count), 6);
`else
    chk("bubble_cnt_off", 32'(bubble_count), 0);
`endif

    // async reset mid-stream with reg_write live in EX
    z = '{default: '0};
    z.v = 1; z.c = ADDC; z.op = 2; z.rs = 3; z.rt = 4; z.pc = 32'hABCD0000;
    drive(z);
    @(posedge clk); #1;
    chk("pre_reset_regwrite", 32'(ex_reg_write), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(ex_valid), 0);
    chk("async_reset_regwrite", 32'(ex_reg_write), 0);
    chk("async_reset_pc", ex_pc_plus4, 0);
    chk("async_reset_cnt", 32'(bubble_count), 0);
    @(negedge clk);
    reset = 1'b0;
    z.pc = 32'h00C0FFEE;
    drive(z);
    @(posedge clk); #1;
    chk("post_reset_valid", 32'(ex_valid), 1);
    chk("post_reset_pc", ex_pc_plus4, 32'h00C0FFEE);
    chk("post_reset_aluop", 32'(ex_alu_op), 2);

`ifdef ID_EX_BUBBLE_CNT_EN
    // drive the counter past all-ones and confirm it saturates
    flush = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("bubble_cnt_sat", 32'(bubble_count), 32'hFFFF);
    flush = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
